// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the two memory requesters (core, UART DMA), the arbiter and the data memory.
// The slave modport is the arbiter's view; the master modport is the requester/memory side.
interface dmem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              core_req;
    logic [1:0]        core_we;
    logic [ADDR_W-1:0] core_addr;
    logic [DATA_W-1:0] core_wdata;
    logic              core_gnt;
    logic              core_rvalid;
    logic [DATA_W-1:0] core_rdata;
    logic              core_stall;

    logic              uart_req;
    logic [1:0]        uart_we;
    logic [ADDR_W-1:0] uart_addr;
    logic [DATA_W-1:0] uart_wdata;
    logic              uart_gnt;
    logic              uart_rvalid;
    logic [DATA_W-1:0] uart_rdata;

    logic              mem_en;
    logic [1:0]        mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  core_req, core_we, core_addr, core_wdata,
        input  uart_req, uart_we, uart_addr, uart_wdata,
        input  mem_rdata,
        output core_gnt, core_rvalid, core_rdata, core_stall,
        output uart_gnt, uart_rvalid, uart_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output core_req, core_we, core_addr, core_wdata,
        output uart_req, uart_we, uart_addr, uart_wdata,
        output mem_rdata,
        input  core_gnt, core_rvalid, core_rdata, core_stall,
        input  uart_gnt, uart_rvalid, uart_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Shares one fixed-latency data-memory port between the core (requester 0) and UART DMA (requester 1),
// one outstanding transaction at a time, with round-robin or core-priority arbitration.
module dmem_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int MEM_LATENCY = 1,
    parameter int RR_EN       = 1
) (
    input logic           clk,
    input logic           reset,
    dmem_arbiter_if.slave bus
);
    localparam int CNT_W = (MEM_LATENCY < 1) ? 1 : $clog2(MEM_LATENCY + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LATENCY - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t            state, state_nx;
    logic [CNT_W-1:0]  cnt, cnt_nx;
    logic              owner, owner_nx;
    logic              last, last_nx;
    logic              winner;
    logic [1:0]        we_lat, we_nx;
    logic [ADDR_W-1:0] addr_lat, addr_nx;
    logic [DATA_W-1:0] wdata_lat, wdata_nx;
    logic              core_done, uart_done;

    // On a tie, round-robin favours whoever did not win last; a lone request always wins.
    always_comb begin
        if (bus.core_req && bus.uart_req)
            winner = (RR_EN != 0) ? ~last : 1'b0;
        else
            winner = bus.uart_req;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            owner     <= 1'b0;
            last      <= 1'b1;
            we_lat    <= 2'b00;
            addr_lat  <= '0;
            wdata_lat <= '0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            owner     <= owner_nx;
            last      <= last_nx;
            we_lat    <= we_nx;
            addr_lat  <= addr_nx;
            wdata_lat <= wdata_nx;
        end
    end

    always_comb begin
        state_nx       = state;
        cnt_nx         = cnt;
        owner_nx       = owner;
        last_nx        = last;
        we_nx          = we_lat;
        addr_nx        = addr_lat;
        wdata_nx       = wdata_lat;
        core_done      = 1'b0;
        uart_done      = 1'b0;
        bus.mem_en     = 1'b0;
        bus.mem_we     = 2'b00;
        bus.mem_addr   = addr_lat;
        bus.mem_wdata  = wdata_lat;
        bus.core_gnt   = 1'b0;
        bus.uart_gnt   = 1'b0;
        bus.core_rdata = '0;
        bus.uart_rdata = '0;
        case (state)
            IDLE: begin
                if (bus.core_req || bus.uart_req) begin
                    state_nx = ISSUE;
                    owner_nx = winner;
                    last_nx  = winner;
                    we_nx    = winner ? bus.uart_we    : bus.core_we;
                    addr_nx  = winner ? bus.uart_addr  : bus.core_addr;
                    wdata_nx = winner ? bus.uart_wdata : bus.core_wdata;
                end
            end
            ISSUE: begin
                bus.mem_en   = 1'b1;
                bus.mem_we   = we_lat;
                bus.core_gnt = ~owner;
                bus.uart_gnt = owner;
                cnt_nx       = CNT_LOAD;
                state_nx     = WAIT;
            end
            WAIT: begin
                if (cnt == '0) begin
                    core_done = ~owner;
                    uart_done = owner;
                    if (owner)
                        bus.uart_rdata = bus.mem_rdata;
                    else
                        bus.core_rdata = bus.mem_rdata;
                    state_nx = IDLE;
                end else begin
                    cnt_nx = cnt - CNT_W'(1);
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign bus.core_rvalid = core_done;
    assign bus.uart_rvalid = uart_done;
    assign bus.core_stall  = bus.core_req & ~core_done;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: u0 (latency 1, round-robin) and u1 (latency 3, core priority),
// each with a latency-accurate memory model and a scoreboard of expected transactions.
module tb_dmem_arbiter;
  typedef struct {
    logic        owner;
    logic [1:0]  we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } sb_t;

  logic clk = 1'b0;
  logic rst_a, rst_b;
  int   total = 0;
  int   bad   = 0;
  sb_t  sb0[$];
  sb_t  sb1[$];
  logic gq[$];
  logic [31:0] pa;
  logic [31:0] pb [3];

  dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) a ();
  dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) b ();

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(1), .RR_EN(1))
    u0 (.clk(clk), .reset(rst_a), .bus(a.slave));
  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(3), .RR_EN(0))
    u1 (.clk(clk), .reset(rst_b), .bus(b.slave));

  always #5 clk = ~clk;

  function automatic logic [31:0] memf(input logic [31:0] ad);
    return (ad == 32'h10) ? 32'hDEADBEEF : ((ad ^ 32'h5A5A_0000) + 32'd7);
  endfunction

  // Read data is only valid exactly MEM_LATENCY cycles after mem_en; otherwise garbage.
  always @(posedge clk) begin
    pa    <= a.mem_en ? memf(a.mem_addr) : 32'hBADBAD00;
    pb[0] <= b.mem_en ? memf(b.mem_addr) : 32'hBADBAD00;
    pb[1] <= pb[0];
    pb[2] <= pb[1];
  end
  assign a.mem_rdata = pa;
  assign b.mem_rdata = pb[2];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int d, input logic o, input logic [1:0] we,
                      input logic [31:0] ad, input logic [31:0] wd);
    sb_t e;
    e.owner = o; e.we = we; e.addr = ad; e.wdata = wd; e.rdata = memf(ad);
    if (d == 0) sb0.push_back(e); else sb1.push_back(e);
  endtask

  task automatic mon(input int d, input logic en, input logic [1:0] we,
                     input logic [31:0] ad, input logic [31:0] wd,
                     input logic cg, input logic ug, input logic cr, input logic ur,
                     input logic [31:0] crd, input logic [31:0] urd);
    sb_t  e;
    logic have;
    have = (d == 0) ? (sb0.size() > 0) : (sb1.size() > 0);
    if (have) e = (d == 0) ? sb0[0] : sb1[0];
    if (en || cg || ug) begin
      check("sb_pending_at_issue", 64'(have), 64'(1'b1));
      if (have) begin
        check("issue_gnt", 64'({cg, ug}), 64'(e.owner ? 2'b01 : 2'b10));
        check("issue_en", 64'(en), 64'(1'b1));
        check("issue_we", 64'(we), 64'(e.we));
        check("issue_addr", 64'(ad), 64'(e.addr));
        check("issue_wdata", 64'(wd), 64'(e.wdata));
      end
    end
    if (cr || ur) begin
      check("sb_pending_at_done", 64'(have), 64'(1'b1));
      if (have) begin
        if (d == 0) void'(sb0.pop_front()); else void'(sb1.pop_front());
        check("done_rvalid", 64'({cr, ur}), 64'(e.owner ? 2'b01 : 2'b10));
        check("done_rdata", 64'(e.owner ? urd : crd), 64'(e.rdata));
        check("other_rdata_zero", 64'(e.owner ? crd : urd), 64'(32'h0));
      end
    end
  endtask

  always @(negedge clk) begin
    mon(0, a.mem_en, a.mem_we, a.mem_addr, a.mem_wdata, a.core_gnt, a.uart_gnt,
        a.core_rvalid, a.uart_rvalid, a.core_rdata, a.uart_rdata);
    mon(1, b.mem_en, b.mem_we, b.mem_addr, b.mem_wdata, b.core_gnt, b.uart_gnt,
        b.core_rvalid, b.uart_rvalid, b.core_rdata, b.uart_rdata);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic collect(input int d, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (d == 0) begin
        if (a.core_gnt || a.uart_gnt) gq.push_back(a.uart_gnt);
      end else begin
        if (b.core_gnt || b.uart_gnt) gq.push_back(b.uart_gnt);
      end
      tick();
    end
  endtask

  function automatic logic [3:0] pack4();
    logic [3:0] gs = 4'b0;
    for (int i = 0; i < gq.size() && i < 4; i++) gs[i] = gq[i];
    return gs;
  endfunction

  task automatic clear_bus();
    a.core_req = 0; a.core_we = 0; a.core_addr = 0; a.core_wdata = 0;
    a.uart_req = 0; a.uart_we = 0; a.uart_addr = 0; a.uart_wdata = 0;
    b.core_req = 0; b.core_we = 0; b.core_addr = 0; b.core_wdata = 0;
    b.uart_req = 0; b.uart_we = 0; b.uart_addr = 0; b.uart_wdata = 0;
  endtask

  initial begin
    logic got;
    rst_a = 1'b1;
    rst_b = 1'b1;
    clear_bus();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_mem_en", 64'(a.mem_en), 64'(1'b0));
    check("rst_handshake", 64'({a.core_gnt, a.uart_gnt, a.core_rvalid, a.uart_rvalid}), 64'(4'b0));
    check("rst_mem_we", 64'(a.mem_we), 64'(2'b00));
    check("rst_mem_addr", 64'(a.mem_addr), 64'(32'h0));
    check("rst_mem_wdata", 64'(a.mem_wdata), 64'(32'h0));
    tick();
    rst_a = 1'b0;
    rst_b = 1'b0;

    // Core read of 0x10; address changes after the IDLE sample must not leak.
    a.core_req = 1; a.core_we = 2'b00; a.core_addr = 32'h10; a.core_wdata = 32'h0;
    push(0, 1'b0, 2'b00, 32'h10, 32'h0);
    @(negedge clk);
    check("rd_stall_n", 64'(a.core_stall), 64'(1'b1));
    check("rd_gnt_n", 64'(a.core_gnt), 64'(1'b0));
    tick();
    a.core_addr = 32'h20;
    @(negedge clk);
    check("rd_gnt_n1", 64'(a.core_gnt), 64'(1'b1));
    check("rd_addr_latched", 64'(a.mem_addr), 64'(32'h10));
    check("rd_stall_n1", 64'(a.core_stall), 64'(1'b1));
    tick();
    @(negedge clk);
    check("rd_rvalid_n2", 64'(a.core_rvalid), 64'(1'b1));
    check("rd_rdata_n2", 64'(a.core_rdata), 64'(32'hDEADBEEF));
    check("rd_stall_n2", 64'(a.core_stall), 64'(1'b0));
    tick();
    a.core_req = 0;
    @(negedge clk);
    check("rd_after_rvalid", 64'(a.core_rvalid), 64'(1'b0));
    check("rd_after_rdata", 64'(a.core_rdata), 64'(32'h0));
    check("rd_after_we", 64'(a.mem_we), 64'(2'b00));

    // UART SB with a one-cycle core pulse during its ISSUE cycle.
    tick();
    a.uart_req = 1; a.uart_we = 2'b11; a.uart_addr = 32'h203; a.uart_wdata = 32'h41;
    push(0, 1'b1, 2'b11, 32'h203, 32'h41);
    @(negedge clk);
    check("sb_gnt_n", 64'(a.uart_gnt), 64'(1'b0));
    tick();
    a.core_req = 1;
    @(negedge clk);
    check("sb_gnt_n1", 64'(a.uart_gnt), 64'(1'b1));
    check("sb_mem_we", 64'(a.mem_we), 64'(2'b11));
    check("sb_mem_addr", 64'(a.mem_addr), 64'(32'h203));
    check("sb_core_gnt", 64'(a.core_gnt), 64'(1'b0));
    tick();
    a.core_req = 0;
    a.uart_req = 0;
    @(negedge clk);
    check("sb_rvalid", 64'(a.uart_rvalid), 64'(1'b1));
    check("sb_core_quiet", 64'({a.core_gnt, a.core_rvalid}), 64'(2'b00));
    check("sb_core_rdata", 64'(a.core_rdata), 64'(32'h0));
    for (int i = 0; i < 3; i++) begin
      tick();
      @(negedge clk);
      check("pulse_no_txn", 64'(a.mem_en), 64'(1'b0));
    end

    // Both requesting continuously under round-robin.
    tick();
    a.core_req = 1; a.core_we = 2'b01; a.core_addr = 32'h100; a.core_wdata = 32'h1111;
    a.uart_req = 1; a.uart_we = 2'b00; a.uart_addr = 32'h300; a.uart_wdata = 32'h0;
    push(0, 1'b0, 2'b01, 32'h100, 32'h1111);
    push(0, 1'b1, 2'b00, 32'h300, 32'h0);
    push(0, 1'b0, 2'b01, 32'h100, 32'h1111);
    push(0, 1'b1, 2'b00, 32'h300, 32'h0);
    gq.delete();
    collect(0, 11);
    a.core_req = 0;
    a.uart_req = 0;
    collect(0, 4);
    check("rr_count", 64'(gq.size()), 64'(4));
    check("rr_order", 64'(pack4()), 64'(4'b1010));
    check("rr_drained", 64'(sb0.size()), 64'(0));

    // Fixed priority, latency 3: uart starves until core lets go.
    b.core_req = 1; b.core_we = 2'b10; b.core_addr = 32'h44; b.core_wdata = 32'hBEEF;
    b.uart_req = 1; b.uart_we = 2'b00; b.uart_addr = 32'h500; b.uart_wdata = 32'h0;
    for (int i = 0; i < 3; i++) push(1, 1'b0, 2'b10, 32'h44, 32'hBEEF);
    push(1, 1'b1, 2'b00, 32'h500, 32'h0);
    gq.delete();
    collect(1, 12);
    b.core_req = 0;
    collect(1, 4);
    b.uart_req = 0;
    collect(1, 6);
    check("fp_count", 64'(gq.size()), 64'(4));
    check("fp_order", 64'(pack4()), 64'(4'b1000));
    check("fp_drained", 64'(sb1.size()), 64'(0));

    // Reset in the middle of WAIT; the held core request is served afresh afterwards.
    b.core_req = 1; b.core_we = 2'b00; b.core_addr = 32'h40; b.core_wdata = 32'h0;
    push(1, 1'b0, 2'b00, 32'h40, 32'h0);
    tick();
    @(negedge clk);
    check("mr_first_gnt", 64'(b.core_gnt), 64'(1'b1));
    tick();
    rst_b = 1'b1;
    @(negedge clk);
    check("mr_mem_en", 64'(b.mem_en), 64'(1'b0));
    check("mr_handshake", 64'({b.core_gnt, b.uart_gnt, b.core_rvalid, b.uart_rvalid}), 64'(4'b0));
    check("mr_mem_we", 64'(b.mem_we), 64'(2'b00));
    check("mr_mem_addr", 64'(b.mem_addr), 64'(32'h0));
    check("mr_rdata", 64'(b.core_rdata), 64'(32'h0));
    tick();
    rst_b = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      got = b.core_gnt | b.uart_gnt;
    end
    check("mr_regnt_seen", 64'(got), 64'(1'b1));
    check("mr_regnt_core", 64'({b.core_gnt, b.uart_gnt}), 64'(2'b10));
    tick();
    b.core_req = 0;
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      got = b.core_rvalid;
      if (!got) tick();
    end
    check("mr_rvalid_seen", 64'(got), 64'(1'b1));
    repeat (3) tick();
    check("mr_drained", 64'(sb1.size()), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
